axi_sub_arb_rr: RTL and testbench

Parametrised N-channel arbiter that merges NCH AXI subordinate request streams (read or write) onto a single register/SRAM component interface. It uses round-robin arbitration with burst locking and hold-stable grants. Read responses are routed back to the originating channel after a fixed component latency C_LAT. It sits between the AXI subordinate front-ends (one or more read/write pairs, or multiple AXI ports) and a shared component.

---
 rtl/axi_sub_arb_rr.sv | 168 ++++++++++++++++
 tb/tb_axi_sub_arb_rr.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/axi_sub_arb_rr.sv
// Round-robin arbiter merging NCH AXI subordinate beat streams onto one component port.
// Grants lock across stalls and multi-beat bursts; read responses are routed back after C_LAT cycles.
module axi_sub_arb_rr #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int UW    = 32,
  parameter int IW    = 1,
  parameter int NCH   = 2,
  parameter int C_LAT = 0,
  localparam int BC   = DW / 8,
  localparam int CW   = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    ch_dv,
  input  logic [NCH-1:0]    ch_write,
  input  logic [NCH*AW-1:0] ch_addr,
  input  logic [NCH*UW-1:0] ch_user,
  input  logic [NCH*IW-1:0] ch_id,
  input  logic [NCH*DW-1:0] ch_wdata,
  input  logic [NCH*BC-1:0] ch_wstrb,
  input  logic [NCH-1:0]    ch_last,
  output logic [NCH-1:0]    ch_hld,
  output logic [NCH-1:0]    ch_err,
  output logic [NCH-1:0]    ch_rvalid,
  output logic [DW-1:0]     ch_rdata,
  output logic              dv,
  output logic [AW-1:0]     addr,
  output logic              write,
  output logic [UW-1:0]     user,
  output logic [IW-1:0]     id,
  output logic [DW-1:0]     wdata,
  output logic [BC-1:0]     wstrb,
  output logic              last,
  input  logic              hld,
  input  logic              rd_err,
  input  logic              wr_err,
  input  logic [DW-1:0]     rdata
);

  logic          lock_vld_q, lock_vld_d;
  logic [CW-1:0] lock_idx_q, lock_idx_d;
  logic [CW-1:0] ptr_q, ptr_d;
  logic          win_found;
  logic [CW-1:0] win_idx;
  logic [NCH-1:0] gnt;
  logic          accept;
  logic          ret_vld;
  logic [CW-1:0] ret_idx;

  function automatic logic [CW-1:0] wrap_add(input logic [CW-1:0] a, input int k);
    int s;
    s = int'(a) + k;
    if (s >= NCH) s = s - NCH;
    return CW'(s);
  endfunction

  // Winner selection: locked channel wins outright, else first requester from ptr
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    if (lock_vld_q) begin
      win_found = 1'b1;
      win_idx   = lock_idx_q;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (!win_found && ch_dv[wrap_add(ptr_q, k)]) begin
          win_found = 1'b1;
          win_idx   = wrap_add(ptr_q, k);
        end
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (win_found) gnt[win_idx] = ch_dv[win_idx];
  end

  assign dv       = |gnt;
  assign accept   = dv && !hld;
  assign ch_hld   = {NCH{hld}} | ~gnt;
  assign ch_rdata = rdata;

  always_comb begin
    addr  = '0;
    write = 1'b0;
    user  = '0;
    id    = '0;
    wdata = '0;
    wstrb = '0;
    last  = 1'b0;
    if (dv) begin
      addr  = ch_addr[int'(win_idx)*AW +: AW];
      write = ch_write[win_idx];
      user  = ch_user[int'(win_idx)*UW +: UW];
      id    = ch_id[int'(win_idx)*IW +: IW];
      wdata = ch_wdata[int'(win_idx)*DW +: DW];
      wstrb = ch_wstrb[int'(win_idx)*BC +: BC];
      last  = ch_last[win_idx];
    end
  end

  // Lock is taken whenever the granted beat cannot complete the burst this cycle
  always_comb begin
    lock_vld_d = lock_vld_q;
    lock_idx_d = lock_idx_q;
    ptr_d      = ptr_q;
    if (accept && last) begin
      lock_vld_d = 1'b0;
      ptr_d      = wrap_add(win_idx, 1);
    end else if (dv && (hld || !last)) begin
      lock_vld_d = 1'b1;
      lock_idx_d = win_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_vld_q <= 1'b0;
      lock_idx_q <= '0;
      ptr_q      <= '0;
    end else begin
      lock_vld_q <= lock_vld_d;
      lock_idx_q <= lock_idx_d;
      ptr_q      <= ptr_d;
    end
  end

  // Read-return pipe: fixed component latency, advances regardless of hld
  if (C_LAT == 0) begin : g_nolat
    assign ret_vld = accept && !write;
    assign ret_idx = win_idx;
  end else begin : g_pipe
    logic [C_LAT-1:0] vld_q;
    logic [CW-1:0]    idx_q [C_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= accept && !write;
        for (int k = 1; k < C_LAT; k++) vld_q[k] <= vld_q[k-1];
      end
    end

    always_ff @(posedge clk) begin
      idx_q[0] <= win_idx;
      for (int k = 1; k < C_LAT; k++) idx_q[k] <= idx_q[k-1];
    end

    assign ret_vld = vld_q[C_LAT-1];
    assign ret_idx = idx_q[C_LAT-1];
  end

  always_comb begin
    ch_rvalid = '0;
    for (int i = 0; i < NCH; i++) ch_err[i] = wr_err && gnt[i] && write;
    if (ret_vld) begin
      ch_rvalid[ret_idx] = 1'b1;
      ch_err[ret_idx]    = ch_err[ret_idx] | rd_err;
    end
  end

  a_one_gnt : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(~ch_hld));
  a_lock_hold : assert property (@(posedge clk) disable iff (!rst_n) lock_vld_q |-> ch_dv[lock_idx_q]);

endmodule

// File: tb/tb_axi_sub_arb_rr.sv
// Directed bench for axi_sub_arb_rr: NCH=3 instances with C_LAT=0 (a_*) and C_LAT=2 (b_*) share stimulus.
module tb_axi_sub_arb_rr;
  localparam int NCH = 3, AW = 32, DW = 32, UW = 32, IW = 1, BC = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [NCH-1:0]    ch_dv, ch_write, ch_last;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH*UW-1:0] ch_user;
  logic [NCH*IW-1:0] ch_id;
  logic [NCH*DW-1:0] ch_wdata;
  logic [NCH*BC-1:0] ch_wstrb;
  logic hld, rd_err, wr_err;
  logic [DW-1:0] rdata;

  logic [NCH-1:0] a_hld, a_err, a_rv, b_hld, b_err, b_rv;
  logic [DW-1:0]  a_rdata, b_rdata, a_wdata, b_wdata;
  logic           a_dv, a_write, a_last, b_dv, b_write, b_last;
  logic [AW-1:0]  a_addr, b_addr;
  logic [UW-1:0]  a_user, b_user;
  logic [IW-1:0]  a_id, b_id;
  logic [BC-1:0]  a_wstrb, b_wstrb;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  axi_sub_arb_rr #(.AW(AW), .DW(DW), .UW(UW), .IW(IW), .NCH(NCH), .C_LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .ch_dv(ch_dv), .ch_write(ch_write), .ch_addr(ch_addr),
    .ch_user(ch_user), .ch_id(ch_id), .ch_wdata(ch_wdata), .ch_wstrb(ch_wstrb),
    .ch_last(ch_last), .ch_hld(a_hld), .ch_err(a_err), .ch_rvalid(a_rv), .ch_rdata(a_rdata),
    .dv(a_dv), .addr(a_addr), .write(a_write), .user(a_user), .id(a_id), .wdata(a_wdata),
    .wstrb(a_wstrb), .last(a_last), .hld(hld), .rd_err(rd_err), .wr_err(wr_err), .rdata(rdata)
  );

  axi_sub_arb_rr #(.AW(AW), .DW(DW), .UW(UW), .IW(IW), .NCH(NCH), .C_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .ch_dv(ch_dv), .ch_write(ch_write), .ch_addr(ch_addr),
    .ch_user(ch_user), .ch_id(ch_id), .ch_wdata(ch_wdata), .ch_wstrb(ch_wstrb),
    .ch_last(ch_last), .ch_hld(b_hld), .ch_err(b_err), .ch_rvalid(b_rv), .ch_rdata(b_rdata),
    .dv(b_dv), .addr(b_addr), .write(b_write), .user(b_user), .id(b_id), .wdata(b_wdata),
    .wstrb(b_wstrb), .last(b_last), .hld(hld), .rd_err(rd_err), .wr_err(wr_err), .rdata(rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge, where inputs are driven
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Move to mid-cycle, where outputs are sampled
  task automatic settle();
    #3;
  endtask

  initial begin
    logic [NCH-1:0] exp_rot [4];
    exp_rot[0] = 3'b110; exp_rot[1] = 3'b101; exp_rot[2] = 3'b011; exp_rot[3] = 3'b110;

    rst_n    = 1'b0;
    ch_dv    = '0;
    ch_write = '0;
    ch_last  = '1;
    ch_addr  = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
    ch_user  = {32'hC2, 32'hC1, 32'hC0};
    ch_id    = 3'b010;
    ch_wdata = {32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    ch_wstrb = {4'hC, 4'h3, 4'hF};
    hld      = 1'b0;
    rd_err   = 1'b0;
    wr_err   = 1'b0;
    rdata    = 32'hDEAD_BEEF;

    // Reset state
    cyc(); settle();
    chk("rst_dv", a_dv, 1'b0);
    chk("rst_hld", b_hld, 3'b111);
    chk("rst_rvalid", b_rv, 3'b000);
    chk("rst_err", a_err, 3'b000);
    chk("rdata_bcast", b_rdata, 32'hDEAD_BEEF);
    cyc(); rst_n = 1'b1;

    // Rotation: all channels single-beat writes
    ch_dv = 3'b111; ch_write = 3'b111; ch_last = 3'b111;
    for (int c = 0; c < 4; c++) begin
      settle();
      chk($sformatf("rot_hld%0d", c), a_hld, exp_rot[c]);
      if (c == 1) chk("rot_addr1", a_addr, 32'h0000_2000);
      cyc();
    end

    // ch1 4-beat read burst with ch0/ch2 requesting; ptr is 1
    ch_write = 3'b101;
    for (int b = 0; b < 4; b++) begin
      ch_last = (b == 3) ? 3'b111 : 3'b101;
      settle();
      chk($sformatf("burst_hld%0d", b), b_hld, 3'b101);
      chk($sformatf("burst_rv0_%0d", b), a_rv, 3'b010);
      if (b >= 2) chk($sformatf("burst_rv2_%0d", b), b_rv, 3'b010);
      cyc();
    end
    ch_last = 3'b111;
    settle();
    chk("after_burst_ch2", b_hld, 3'b011);
    chk("lat2_rv_b3", b_rv, 3'b010);
    cyc(); settle();
    chk("after_burst_ch0", b_hld, 3'b110);
    chk("lat2_rv_b4", b_rv, 3'b010);
    cyc(); ch_dv = 3'b000;
    cyc(); cyc();

    // Stall while ch2 granted; ptr is 1
    ch_dv = 3'b100; ch_write = 3'b111; hld = 1'b1;
    settle();
    chk("hold1_dv", a_dv, 1'b1);
    chk("hold1_addr", a_addr, 32'h0000_3000);
    chk("hold1_hld", a_hld, 3'b111);
    cyc(); ch_dv = 3'b101;
    settle();
    chk("hold2_addr", a_addr, 32'h0000_3000);
    chk("hold2_hld", a_hld, 3'b111);
    cyc(); settle();
    chk("hold3_addr", b_addr, 32'h0000_3000);
    cyc(); hld = 1'b0;
    settle();
    chk("hold_release", a_hld, 3'b011);
    cyc(); ch_dv = 3'b001;
    settle();
    chk("after_hold_ch0", a_hld, 3'b110);
    chk("after_hold_addr", a_addr, 32'h0000_1000);

    // Write error on ch1; ptr is 1
    cyc(); ch_dv = 3'b010; wr_err = 1'b1;
    settle();
    chk("wr_err_ch", a_err, 3'b010);
    chk("wr_err_ch_lat2", b_err, 3'b010);
    chk("wr_write", a_write, 1'b1);
    chk("wr_wstrb", a_wstrb, 4'h3);
    chk("wr_wdata", a_wdata, 32'h1111_1111);

    // Read returns; ptr is 2
    cyc(); wr_err = 1'b0; ch_write = 3'b000; ch_dv = 3'b001;
    settle();
    chk("rd0_lat0", a_rv, 3'b001);
    cyc(); ch_dv = 3'b010;
    settle();
    chk("rd1_lat0", a_rv, 3'b010);
    cyc(); ch_dv = 3'b000;
    settle();
    chk("rd0_lat2_rv", b_rv, 3'b001);
    chk("rd0_lat2_err", b_err, 3'b000);
    cyc(); rd_err = 1'b1;
    settle();
    chk("rd1_lat2_rv", b_rv, 3'b010);
    chk("rd1_lat2_err", b_err, 3'b010);
    chk("rd_err_lat0_none", a_err, 3'b000);
    cyc();
    settle();
    chk("rd_lat2_rv_done", b_rv, 3'b000);
    chk("rd_lat2_err_done", b_err, 3'b000);

    // Reset in the middle of a ch2 read burst with pipe full; ptr is 2
    cyc(); rd_err = 1'b0; ch_dv = 3'b100; ch_last = 3'b000;
    settle();
    chk("rb_beat1", b_hld, 3'b011);
    cyc(); cyc();
    settle();
    chk("rb_pipe_full", b_rv, 3'b100);
    #1 rst_n = 1'b0;
    #1;
    chk("rb_async_rv", b_rv, 3'b000);
    ch_dv = 3'b101;
    #1;
    chk("rb_unlocked", b_hld, 3'b110);
    cyc(); rst_n = 1'b1; ch_dv = 3'b000; ch_last = 3'b111;
    settle();
    chk("rb_no_rv1", b_rv, 3'b000);
    cyc(); settle();
    chk("rb_no_rv2", b_rv, 3'b000);
    cyc(); ch_dv = 3'b110; ch_write = 3'b111;
    settle();
    chk("rb_ptr_reset", b_hld, 3'b101);
    cyc(); ch_dv = 3'b000;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
